mbist_data_cmp_log: RTL and testbench
=====================================

// Module: mbist_data_cmp_log
// PURPOSE
//  Next-generation MBIST read-data comparator with a repair log. Sits between the MBIST FSM/pattern
//  generator and the repair controller. Compares masked SRAM read data against the expected pattern
//  and logs unique failing addresses into an addressable error log. Accumulates a sticky per-bit fail
//  map. Flags repairable vs. unrepairable outcomes. Log entries are drained by the repair/debug
//  logic over a valid/ready pop interface.
// PARAMETERS
//  DATA_WD    32  read/expected data width
//  ADDR_WD    10  memory address width
//  ERR_LIMIT  4   max unique failing addresses repairable; also the log depth (>=1)
//  BIT_WD     $clog2(DATA_WD)    width of failing-bit index
//  CNT_WD     $clog2(ERR_LIMIT+1) width of unique-error counter
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        reset: asynchronous, active-low
//  clear       in   1        synchronous clear of all state (start of new BIST run)
//  compare     in   1        rxd_data/addr are valid this cycle, compare them
//  read_invert in   1        expected = ~comp_data when 1
//  comp_data   in   DATA_WD  expected pattern
//  rxd_data    in   DATA_WD  data read from memory
//  bit_mask    in   DATA_WD  1 = ignore this bit in the comparison
//  addr        in   ADDR_WD  address of rxd_data
//  error       out  1        sticky: unique failure seen with err_cnt==ERR_LIMIT (unrepairable)
//  error_fix   out  1        1-cycle pulse: new unique failing address logged
//  correct     out  1        sticky: at least one address logged (repair required)
//  err_cnt     out  CNT_WD   unique failing addresses logged, saturates at ERR_LIMIT
//  fail_bits   out  DATA_WD  sticky OR of all masked mismatch vectors
//  log_vld     out  1        log non-empty; log_addr/log_bit show oldest entry
//  log_addr    out  ADDR_WD  failing address of oldest entry
//  log_bit     out  BIT_WD   lowest failing bit index of oldest entry
//  log_pop     in   1        pop oldest entry; ignored when log_vld==0
// BEHAVIOUR
//  - Reset and clear: all outputs 0. Log empty. err_cnt=0. clear has priority over every other event.
//  - Stage 1, at the edge after compare=1:
//      mis_q  <= (exp ^ rxd_data) & ~bit_mask
//      addr_q <= addr
//      vld_q  <= 1
//    With compare=0: vld_q <= 0, mis_q/addr_q hold.
//  - Stage 2, at the next edge when vld_q && |mis_q:
//      fail_bits |= mis_q, always, including duplicate and overflow cases.
//      hit = addr_q matches any currently valid log entry.
//      hit: no further action (duplicate suppressed, no error_fix).
//      !hit && err_cnt<ERR_LIMIT: push {addr_q, lowest set bit of mis_q}; err_cnt++; error_fix=1 for
//        one cycle; correct<=1.
//      !hit && err_cnt==ERR_LIMIT: error<=1 (sticky); nothing pushed; err_cnt holds.
//  - Latency: compare at cycle N -> error_fix/error/fail_bits visible after edge N+2.
//  - Back-to-back compares: fully pipelined, one compare per cycle. Consecutive fails on the same
//    address log once (stage-2 lookup includes an entry pushed in the previous cycle).
//  - err_cnt counts pushes, not occupancy; pops never decrement it. Because the log depth equals
//    ERR_LIMIT, a push can never find the log full.
//  - Pop: on an edge with log_pop && log_vld, the oldest entry is removed. Pop and push in the same
//    cycle are both performed. The dedup lookup uses pre-pop contents; a popped address that fails
//    again is a new unique error.
//  - Pointers wrap modulo ERR_LIMIT (non-power-of-2 depth supported). Occupancy counter: 0..ERR_LIMIT.
//  - bit_mask all-ones: a compare never fails.
//  - Reset asserted mid-run: immediate clear, in-flight stage-1 result lost.
//  - error and correct may both be 1 (log full, plus overflow).
// STRUCTURE
//  - mbist_pkg (shared): default widths, ERR_LIMIT, typedef struct packed {addr; bit_idx} err_entry_t,
//    function lowest_set_idx().
//  - Sub-module mbist_err_log: ERR_LIMIT-entry FIFO with a parallel address-match (CAM) port,
//    push/pop/clear, and occupancy out.
//  - Top level: stage-1 compare register, stage-2 decision logic, sticky flags, err_cnt.
// TESTING
//  1 No fail: 1024 compares with rxd==comp_data and read_invert 0/1
//    -> error=correct=error_fix=0, fail_bits=0, log_vld=0.
//  2 Single fail: addr 0x05, rxd=comp^32'h0000_0100
//    -> error_fix pulse at N+2; err_cnt=1; log_addr=0x05; log_bit=8; fail_bits=0x100; correct=1.
//  3 Duplicate/mask: addr 0x05 fails 3x back-to-back, then bit 8 masked on addr 0x06
//    -> one log entry only; err_cnt=1; addr 0x06 not logged.
//  4 Overflow: fails at 0x10,0x11,0x12,0x13,0x14 (ERR_LIMIT=4)
//    -> 4 error_fix pulses; err_cnt=4; error=1 after the 0x14 compare;
//    log pops yield 0x10..0x13 in order.
//  5 Pop+push same cycle: log holds 2 entries, pop coincident with a new fail at 0x20
//    -> occupancy stays 2; 0x20 is last entry; a later 0x10 re-fail after its pop counts as new.
//  6 clear and async rst_n asserted mid-run with a full log
//    -> all outputs 0 immediately (rst_n) or next edge (clear); a compare in flight is dropped.

Source files
------------

// File: rtl/mbist_data_cmp_log_pkg.sv
// Shared MBIST comparator definitions: default geometry, log entry layout and
// the failing-bit priority encoder used when an entry is logged.
package mbist_data_cmp_log_pkg;

  localparam int DEF_DATA_WD   = 32;
  localparam int DEF_ADDR_WD   = 10;
  localparam int DEF_ERR_LIMIT = 4;
  localparam int DEF_BIT_WD    = $clog2(DEF_DATA_WD);
  localparam int DEF_CNT_WD    = $clog2(DEF_ERR_LIMIT + 1);

  // Encoder input is sized for the widest supported data bus; callers zero-extend.
  localparam int LSI_MAX_WD    = 256;

  typedef struct packed {
    logic [DEF_ADDR_WD-1:0] addr;
    logic [DEF_BIT_WD-1:0]  bit_idx;
  } err_entry_t;

  function automatic int lowest_set_idx(input logic [LSI_MAX_WD-1:0] vec);
    int idx;
    idx = 0;
    for (int i = LSI_MAX_WD - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mbist_data_cmp_log_if.sv
// Compare/status/pop bundle between the MBIST engine, the comparator and the
// repair controller. master = engine/repair side, slave = comparator.
interface mbist_data_cmp_log_if
  import mbist_data_cmp_log_pkg::*;
#(
  parameter int DATA_WD   = DEF_DATA_WD,
  parameter int ADDR_WD   = DEF_ADDR_WD,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT
);
  localparam int BIT_WD = $clog2(DATA_WD);
  localparam int CNT_WD = $clog2(ERR_LIMIT + 1);

  logic               clear;
  logic               compare;
  logic               read_invert;
  logic [DATA_WD-1:0] comp_data;
  logic [DATA_WD-1:0] rxd_data;
  logic [DATA_WD-1:0] bit_mask;
  logic [ADDR_WD-1:0] addr;
  logic               error;
  logic               error_fix;
  logic               correct;
  logic [CNT_WD-1:0]  err_cnt;
  logic [DATA_WD-1:0] fail_bits;
  logic               log_vld;
  logic [ADDR_WD-1:0] log_addr;
  logic [BIT_WD-1:0]  log_bit;
  logic               log_pop;

  modport master (
    output clear, compare, read_invert, comp_data, rxd_data, bit_mask, addr, log_pop,
    input  error, error_fix, correct, err_cnt, fail_bits, log_vld, log_addr, log_bit
  );

  modport slave (
    input  clear, compare, read_invert, comp_data, rxd_data, bit_mask, addr, log_pop,
    output error, error_fix, correct, err_cnt, fail_bits, log_vld, log_addr, log_bit
  );

endinterface

// File: rtl/mbist_data_cmp_log_err_log.sv
// Failing-address log: circular FIFO of {addr, bit} entries with a parallel
// address match over the valid entries, used to suppress duplicate failures.
module mbist_err_log #(
  parameter int ADDR_WD = 10,
  parameter int BIT_WD  = 5,
  parameter int DEPTH   = 4,
  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_WD = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [ADDR_WD-1:0] push_addr,
  input  logic [BIT_WD-1:0]  push_bit,
  input  logic               pop,
  input  logic [ADDR_WD-1:0] match_addr,
  output logic               hit,
  output logic [ADDR_WD-1:0] head_addr,
  output logic [BIT_WD-1:0]  head_bit,
  output logic [OCC_WD-1:0]  occ
);

  logic [ADDR_WD-1:0] addr_mem_r [DEPTH];
  logic [BIT_WD-1:0]  bit_mem_r  [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_WD-1:0]  wr_ptr_r;
  logic [PTR_WD-1:0]  rd_ptr_r;
  logic [OCC_WD-1:0]  occ_r;
  logic               pop_s;
  logic               push_s;
  logic               hit_s;

  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    if (p == PTR_WD'(DEPTH - 1)) begin
      return {PTR_WD{1'b0}};
    end else begin
      return p + PTR_WD'(1);
    end
  endfunction

  // Qualify pop/push against occupancy and search the valid entries (pre-pop contents).
  always_comb begin
    pop_s  = pop && (occ_r != {OCC_WD{1'b0}});
    push_s = push && ((occ_r != OCC_WD'(DEPTH)) || pop_s);
    hit_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && (addr_mem_r[i] == match_addr)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // FIFO storage, per-entry valid bits, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_WD{1'b0}};
      rd_ptr_r <= {PTR_WD{1'b0}};
      occ_r    <= {OCC_WD{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_WD{1'b0}};
        bit_mem_r[i]  <= {BIT_WD{1'b0}};
      end
    end else if (clear) begin
      valid_r  <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_WD{1'b0}};
      rd_ptr_r <= {PTR_WD{1'b0}};
      occ_r    <= {OCC_WD{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_WD{1'b0}};
        bit_mem_r[i]  <= {BIT_WD{1'b0}};
      end
    end else begin
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= ptr_inc(rd_ptr_r);
      end
      // Push is written after pop so a full-log pop+push keeps the new entry valid.
      if (push_s) begin
        valid_r[wr_ptr_r]    <= 1'b1;
        addr_mem_r[wr_ptr_r] <= push_addr;
        bit_mem_r[wr_ptr_r]  <= push_bit;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_WD'(1);
        2'b01:   occ_r <= occ_r - OCC_WD'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign hit       = hit_s;
  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_bit  = bit_mem_r[rd_ptr_r];
  assign occ       = occ_r;

endmodule

// File: rtl/mbist_data_cmp_log.sv
// MBIST read-data comparator: two-stage compare/decide pipeline feeding a
// deduplicating failing-address log, sticky fail map and repairability flags.
module mbist_data_cmp_log
  import mbist_data_cmp_log_pkg::*;
#(
  parameter int DATA_WD   = DEF_DATA_WD,
  parameter int ADDR_WD   = DEF_ADDR_WD,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mbist_data_cmp_log_if.slave  bus
);

  localparam int BIT_WD = $clog2(DATA_WD);
  localparam int CNT_WD = $clog2(ERR_LIMIT + 1);

  logic [DATA_WD-1:0] exp_s;
  logic [DATA_WD-1:0] mis_s;
  logic [DATA_WD-1:0] mis_r;
  logic [ADDR_WD-1:0] addr_r;
  logic               vld_r;
  logic               hit_s;
  logic               fail_s;
  logic               new_s;
  logic               push_s;
  logic               ovf_s;
  logic [BIT_WD-1:0]  push_bit_s;
  logic [CNT_WD-1:0]  occ_s;
  logic [ADDR_WD-1:0] head_addr_s;
  logic [BIT_WD-1:0]  head_bit_s;
  logic               error_r;
  logic               error_fix_r;
  logic               correct_r;
  logic [CNT_WD-1:0]  err_cnt_r;
  logic [DATA_WD-1:0] fail_bits_r;

  // Stage-1 mismatch and stage-2 decision: new unique failure either logs or overflows.
  always_comb begin
    exp_s      = bus.read_invert ? ~bus.comp_data : bus.comp_data;
    mis_s      = (exp_s ^ bus.rxd_data) & ~bus.bit_mask;
    fail_s     = vld_r && (|mis_r);
    new_s      = fail_s && !hit_s;
    push_bit_s = BIT_WD'(lowest_set_idx(LSI_MAX_WD'(mis_r)));
    push_s     = 1'b0;
    ovf_s      = 1'b0;
    if (new_s && (err_cnt_r < CNT_WD'(ERR_LIMIT))) begin
      push_s = 1'b1;
    end else if (new_s) begin
      ovf_s = 1'b1;
    end else begin
      push_s = 1'b0;
      ovf_s  = 1'b0;
    end
  end

  // Stage-1 compare register; mismatch/address hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r  <= 1'b0;
      mis_r  <= {DATA_WD{1'b0}};
      addr_r <= {ADDR_WD{1'b0}};
    end else if (bus.clear) begin
      vld_r  <= 1'b0;
      mis_r  <= {DATA_WD{1'b0}};
      addr_r <= {ADDR_WD{1'b0}};
    end else if (bus.compare) begin
      vld_r  <= 1'b1;
      mis_r  <= mis_s;
      addr_r <= bus.addr;
    end else begin
      vld_r  <= 1'b0;
    end
  end

  // Sticky flags, fail map and push counter (counts pushes, never decremented by pops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r     <= 1'b0;
      error_fix_r <= 1'b0;
      correct_r   <= 1'b0;
      err_cnt_r   <= {CNT_WD{1'b0}};
      fail_bits_r <= {DATA_WD{1'b0}};
    end else if (bus.clear) begin
      error_r     <= 1'b0;
      error_fix_r <= 1'b0;
      correct_r   <= 1'b0;
      err_cnt_r   <= {CNT_WD{1'b0}};
      fail_bits_r <= {DATA_WD{1'b0}};
    end else begin
      error_fix_r <= push_s;
      if (push_s) begin
        err_cnt_r <= err_cnt_r + CNT_WD'(1);
        correct_r <= 1'b1;
      end
      if (ovf_s) begin
        error_r <= 1'b1;
      end
      if (fail_s) begin
        fail_bits_r <= fail_bits_r | mis_r;
      end
    end
  end

  mbist_err_log #(
    .ADDR_WD (ADDR_WD),
    .BIT_WD  (BIT_WD),
    .DEPTH   (ERR_LIMIT)
  ) u_log (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (bus.clear),
    .push       (push_s),
    .push_addr  (addr_r),
    .push_bit   (push_bit_s),
    .pop        (bus.log_pop),
    .match_addr (addr_r),
    .hit        (hit_s),
    .head_addr  (head_addr_s),
    .head_bit   (head_bit_s),
    .occ        (occ_s)
  );

  assign bus.error     = error_r;
  assign bus.error_fix = error_fix_r;
  assign bus.correct   = correct_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.fail_bits = fail_bits_r;
  assign bus.log_vld   = (occ_s != {CNT_WD{1'b0}});
  assign bus.log_addr  = head_addr_s;
  assign bus.log_bit   = head_bit_s;

endmodule

// File: tb/tb_mbist_data_cmp_log.sv
// Scoreboard bench: stimulus queues expected error_fix events and log entries,
// a negedge monitor checks them as the DUT presents them.
module tb_mbist_data_cmp_log;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    int       at_cyc;
    int       cnt;
  } fix_t;

  fix_t         fix_q[$];
  logic [14:0]  log_q[$];

  mbist_data_cmp_log_if #(.DATA_WD(32), .ADDR_WD(10), .ERR_LIMIT(4)) bus ();

  mbist_data_cmp_log #(.DATA_WD(32), .ADDR_WD(10), .ERR_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: error_fix against queued expectations, popped entries against the log model.
  always @(negedge clk) begin
    logic exp_fix;
    logic exp_v;
    logic [14:0] ent;
    exp_fix = (fix_q.size() > 0) && (fix_q[0].at_cyc == cyc);
    if (bus.error_fix || exp_fix) begin
      chk("error_fix", bus.error_fix, exp_fix);
      if (exp_fix) begin
        if (bus.error_fix) chk("err_cnt_at_fix", bus.err_cnt, fix_q[0].cnt);
        void'(fix_q.pop_front());
      end
    end
    if (bus.log_pop && rst_n) begin
      exp_v = (log_q.size() > 0);
      chk("log_vld_at_pop", bus.log_vld, exp_v);
      if (exp_v && bus.log_vld) begin
        ent = log_q.pop_front();
        chk("pop_log_addr", bus.log_addr, ent[14:5]);
        chk("pop_log_bit", bus.log_bit, ent[4:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.compare = 1'b0;
    bus.log_pop = 1'b0;
    bus.clear   = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input logic [9:0] a, input logic [31:0] comp, input logic [31:0] flip,
                       input logic [31:0] mask, input logic inv, input bit logs,
                       input logic [4:0] bi, input int cnt);
    bus.compare     = 1'b1;
    bus.addr        = a;
    bus.comp_data   = comp;
    bus.read_invert = inv;
    bus.rxd_data    = (inv ? ~comp : comp) ^ flip;
    bus.bit_mask    = mask;
    if (logs) begin
      fix_q.push_back('{at_cyc: cyc + 2, cnt: cnt});
      log_q.push_back({a, bi});
    end
    step();
  endtask

  task automatic pop_n(input int n);
    bus.compare = 1'b0;
    bus.log_pop = 1'b1;
    repeat (n) step();
    bus.log_pop = 1'b0;
  endtask

  task automatic do_clear();
    bus.compare = 1'b0;
    bus.clear   = 1'b1;
    log_q.delete();
    step();
    bus.clear   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_error"}, bus.error, 1'b0);
    chk({tag, "_correct"}, bus.correct, 1'b0);
    chk({tag, "_error_fix"}, bus.error_fix, 1'b0);
    chk({tag, "_err_cnt"}, bus.err_cnt, 3'd0);
    chk({tag, "_fail_bits"}, bus.fail_bits, 32'h0);
    chk({tag, "_log_vld"}, bus.log_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.compare = 1'b0; bus.read_invert = 1'b0; bus.log_pop = 1'b0;
    bus.comp_data = 32'h0; bus.rxd_data = 32'h0; bus.bit_mask = 32'h0; bus.addr = 10'h0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: no failures, plain and inverted reads, then fully masked mismatches
    for (int i = 0; i < 1024; i++) begin
      issue(10'(i), $urandom(), 32'h0, $urandom(), i[0], 1'b0, 5'd0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      issue(10'(i), $urandom(), $urandom() | 32'h1, 32'hFFFF_FFFF, i[0], 1'b0, 5'd0, 0);
    end
    idle(3);
    chk_zero("nofail");

    // 2: single failure on bit 8 at address 0x05
    issue(10'h005, 32'hA5A5_1234, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 5'd8, 1);
    idle(3);
    chk("single_fail_bits", bus.fail_bits, 32'h0000_0100);
    chk("single_correct", bus.correct, 1'b1);
    chk("single_err_cnt", bus.err_cnt, 3'd1);
    chk("single_error", bus.error, 1'b0);
    chk("single_log_vld", bus.log_vld, 1'b1);
    chk("single_log_addr", bus.log_addr, 10'h005);
    chk("single_log_bit", bus.log_bit, 5'd8);

    // 3: back-to-back duplicates at 0x05 (fail map still accumulates), masked fail at 0x06
    issue(10'h005, 32'h1357_9BDF, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 5'd0, 0);
    issue(10'h005, 32'h1357_9BDF, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 5'd0, 0);
    issue(10'h005, 32'h1357_9BDF, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 5'd0, 0);
    issue(10'h006, 32'h2468_ACE0, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0, 5'd0, 0);
    idle(3);
    chk("dup_err_cnt", bus.err_cnt, 3'd1);
    chk("dup_fail_bits", bus.fail_bits, 32'h0000_0110);
    chk("dup_log_addr", bus.log_addr, 10'h005);
    pop_n(1);
    chk("dup_log_empty", bus.log_vld, 1'b0);
    chk("dup_err_cnt_after_pop", bus.err_cnt, 3'd1);
    do_clear();
    chk_zero("clear1");

    // 4: overflow, fifth unique address sets error exactly after its stage 2
    issue(10'h010, 32'h0F0F_0F0F, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 5'd31, 1);
    issue(10'h011, 32'h0F0F_0F0F, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 5'd0,  2);
    issue(10'h012, 32'h0F0F_0F0F, 32'h0000_0006, 32'h0, 1'b0, 1'b1, 5'd1,  3);
    issue(10'h013, 32'h0F0F_0F0F, 32'h0001_0000, 32'h0, 1'b0, 1'b1, 5'd16, 4);
    issue(10'h014, 32'h0F0F_0F0F, 32'h0000_0020, 32'h0, 1'b0, 1'b0, 5'd0,  0);
    bus.compare = 1'b0;
    chk("ovf_error_before", bus.error, 1'b0);
    step();
    chk("ovf_error_after", bus.error, 1'b1);
    idle(2);
    chk("ovf_err_cnt", bus.err_cnt, 3'd4);
    chk("ovf_correct", bus.correct, 1'b1);
    chk("ovf_fail_bits", bus.fail_bits, 32'h8001_0027);
    pop_n(4);
    chk("ovf_log_empty", bus.log_vld, 1'b0);
    chk("ovf_error_sticky", bus.error, 1'b1);
    do_clear();
    chk_zero("clear2");

    // 5: pop coincident with a new push, then re-fail of a popped address
    issue(10'h010, 32'h5555_AAAA, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 5'd2, 1);
    issue(10'h011, 32'h5555_AAAA, 32'h0000_0008, 32'h0, 1'b0, 1'b1, 5'd3, 2);
    idle(3);
    issue(10'h020, 32'h5555_AAAA, 32'h0000_0080, 32'h0, 1'b0, 1'b1, 5'd7, 3);
    pop_n(1);
    chk("pp_log_vld", bus.log_vld, 1'b1);
    chk("pp_log_addr", bus.log_addr, 10'h011);
    chk("pp_err_cnt", bus.err_cnt, 3'd3);
    issue(10'h010, 32'h5555_AAAA, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 5'd2, 4);
    idle(3);
    chk("pp_err_cnt_refail", bus.err_cnt, 3'd4);
    chk("pp_error", bus.error, 1'b0);
    pop_n(3);
    chk("pp_log_empty", bus.log_vld, 1'b0);
    do_clear();

    // 6a: clear with full log and an overflowing compare in flight
    for (int i = 0; i < 4; i++) begin
      issue(10'h030 + 10'(i), 32'hDEAD_BEEF, 32'h1 << i, 32'h0, 1'b0, 1'b1, 5'(i), i + 1);
    end
    idle(3);
    issue(10'h035, 32'hDEAD_BEEF, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 5'd0, 0);
    bus.compare = 1'b0;
    bus.clear   = 1'b1;
    log_q.delete();
    #1;
    chk("clr_correct_before_edge", bus.correct, 1'b1);
    step();
    bus.clear = 1'b0;
    chk_zero("clr_edge");
    idle(2);
    chk_zero("clr_dropped");

    // 6b: asynchronous reset mid-cycle with full log and a compare in flight
    for (int i = 0; i < 4; i++) begin
      issue(10'h040 + 10'(i), 32'h0BAD_F00D, 32'h10 << i, 32'h0, 1'b1, 1'b1, 5'(i + 4), i + 1);
    end
    idle(3);
    chk("rst_pre_correct", bus.correct, 1'b1);
    issue(10'h044, 32'h0BAD_F00D, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 5'd0, 0);
    bus.compare = 1'b0;
    #2;
    rst_n = 1'b0;
    log_q.delete();
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    chk_zero("rst_dropped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
